ram_sp_ctrl: RTL and testbench
==============================

RAM_SP_CTRL -- requirements
Module: ram_sp_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width.
REQ-002 SHALL have parameter AWIDTH, default 12, address width; RAM depth 2**AWIDTH.
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports wr_valid input 1, wr_ready output 1, wr_addr input AWIDTH, wr_data input DWIDTH: write request channel.
REQ-006 SHALL have ports rd_valid input 1, rd_ready output 1, rd_addr input AWIDTH: read request channel.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output DWIDTH: read response channel.
REQ-008 SHALL have ports ram_wren output 1, ram_address output AWIDTH, ram_data output DWIDTH, ram_q input DWIDTH: drive a single-port RAM with registered read (q valid the cycle after address is presented).

Function
REQ-009 SHALL transfer on a channel when valid and ready are both high at a rising clock edge; valid-side signals may not depend on ready.
REQ-010 SHALL grant at most one RAM access per cycle; a transfer on wr or rd channel in cycle N equals a RAM access in cycle N.
REQ-011 SHALL drive ram_wren=1, ram_address=wr_addr, ram_data=wr_data combinationally in a write-grant cycle; ram_wren=0 otherwise.
REQ-012 SHALL drive ram_address=rd_addr in a read-grant cycle; in idle cycles ram_address=rd_addr, ram_wren=0.
REQ-013 SHALL compute read credit = 2 - fifo_count - inflight + (rsp_valid & rsp_ready); a read is eligible only if credit > 0.
REQ-014 SHALL arbitrate with a 1-bit round-robin pointer when write and eligible read both request: grant the side not granted at the previous conflict; pointer toggles only on conflict cycles; reset value favours write.
REQ-015 SHALL grant the single requester when only one is valid (read only if eligible), without changing the pointer.
REQ-016 SHALL set inflight=1 at the edge ending a read-grant cycle N, capture ram_q into a 2-entry response FIFO at the edge ending N+1, assert rsp_valid from N+2; accept-to-response latency exactly 2 cycles with empty FIFO.
REQ-017 SHALL sustain one read per cycle with rsp_ready held high; with rsp_ready low, SHALL stall rd_ready after two outstanding reads and never drop or overwrite a response.
REQ-018 SHALL preserve program order: a read granted after a write to the same address returns the new data; no forwarding logic needed since accesses are serialised.
REQ-019 SHALL keep rsp_data stable while rsp_valid=1 and rsp_ready=0.
REQ-020 SHALL handle simultaneous FIFO push and pop in one cycle with count unchanged.

Reset
REQ-021 SHALL, while reset_n=0 at a clock edge, clear inflight, FIFO count and pointers, rr pointer to write-first; outputs wr_ready=0, rd_ready=0, rsp_valid=0, ram_wren=0.
REQ-022 SHALL discard any in-flight read or buffered response on reset mid-operation; no response emerges after reset release for pre-reset requests.
REQ-023 SHALL not reset RAM contents; rsp_data reset value is don't-care.

Structure
REQ-024 SHALL keep credit depth (2) and read latency (1) as localparams; no shared package required.
REQ-025 SHALL implement the 2-entry response buffer as sub-module ram_sp_rsp_fifo (parameter DWIDTH), instantiated once.

Verification
REQ-026 Reset then single write addr 0x010 data 0xA5, read 0x010 -> rsp_data 0xA5, rsp_valid 2 cycles after read accept.
REQ-027 wr_valid and rd_valid held high for 6 cycles from reset -> grants alternate W,R,W,R,W,R; ram_wren pattern 1,0,1,0,1,0.
REQ-028 Back-to-back reads 0x000..0x007 with rsp_ready=1 -> 8 responses on 8 consecutive cycles, in order, no stalls.
REQ-029 rsp_ready=0, rd_valid held high -> exactly 2 reads accepted then rd_ready=0; release rsp_ready -> both responses in order, reads resume.
REQ-030 Write 0x3FF=0x5A then immediately read 0x3FF in next cycle -> response 0x5A.
REQ-031 Assert reset_n=0 one cycle after a read accept -> rsp_valid stays 0 through and after reset, no stale response.

Source files
------------

// File: rtl/ram_sp_ctrl_pkg.sv
// Shared types for the single-port RAM controller.
// Round-robin pointer encoding and its update helper.
package ram_sp_ctrl_pkg;

    typedef enum logic {
        RR_WR = 1'b0,
        RR_RD = 1'b1
    } rr_t;

    function automatic rr_t rr_flip(input rr_t p);
        return (p == RR_WR) ? RR_RD : RR_WR;
    endfunction

endpackage

// File: rtl/ram_sp_rsp_fifo.sv
// Two-entry read response buffer.
// Head entry stays put until popped, so data is stable under backpressure.
module ram_sp_rsp_fifo #(
    parameter int DWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DWIDTH-1:0] data,
    output logic [1:0]        count
);

    logic [DWIDTH-1:0] mem [2];
    logic              wp;
    logic              rp;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= 2'd0;
            wp    <= 1'b0;
            rp    <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign valid = (count != 2'd0);
    assign data  = mem[rp];

endmodule

// File: rtl/ram_sp_ctrl.sv
// Arbitrates write and read request channels onto one single-port RAM.
// Read responses are buffered with credit-based flow control.
module ram_sp_ctrl
    import ram_sp_ctrl_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              ram_wren,
    output logic [AWIDTH-1:0] ram_address,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_q
);

    localparam int CREDITS = 2;
    localparam int RD_LAT  = 1;

    rr_t               rr;
    logic [RD_LAT-1:0] pipe;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              rd_elig;
    logic              conflict;
    logic              grant_w;
    logic              grant_r;

    assign pop = rsp_valid & rsp_ready;

    // A slot freed by this cycle's pop may be reused immediately.
    assign rd_elig = (3'(fifo_count) + 3'(pipe[RD_LAT-1]))
                   < (3'(CREDITS) + 3'(pop));

    assign conflict = wr_valid & rd_valid & rd_elig;

    assign grant_w = reset_n & wr_valid
                   & (~conflict | (rr == RR_WR));
    assign grant_r = reset_n & rd_valid & rd_elig
                   & (~conflict | (rr == RR_RD));

    assign wr_ready    = grant_w;
    assign rd_ready    = grant_r;
    assign ram_wren    = grant_w;
    assign ram_address = grant_w ? wr_addr : rd_addr;
    assign ram_data    = wr_data;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr   <= RR_WR;
            pipe <= '0;
        end else begin
            pipe <= RD_LAT'({pipe, grant_r});
            if (conflict) begin
                rr <= rr_flip(rr);
            end
        end
    end

    ram_sp_rsp_fifo #(
        .DWIDTH(DWIDTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (pipe[RD_LAT-1]),
        .push_data(ram_q),
        .pop      (pop),
        .valid    (rsp_valid),
        .data     (rsp_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Randomized and directed bench for ram_sp_ctrl.
// Transaction-level model: a data queue with due cycles and a reference memory.
module tb_ram_sp_ctrl;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_wren;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    always #5 clock = ~clock;

    ram_sp_ctrl #(
        .DWIDTH(DW),
        .AWIDTH(AW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .ram_wren   (ram_wren),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_q      (ram_q)
    );

    function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // External RAM: registered read, unwritten words hold a seed pattern.
    logic [DW-1:0] ram [1<<AW];
    bit            written [1<<AW];

    always @(posedge clock) begin
        if (ram_wren) begin
            ram[ram_address]     <= ram_data;
            written[ram_address] <= 1'b1;
        end
        ram_q <= written[ram_address] ? ram[ram_address]
                                      : seed_val(ram_address);
    end

    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    bit            rr_rd;
    int            cyc;
    int            checks;
    int            failures;
    bit            last_gw;
    bit            last_gr;
    logic [DW-1:0] last_rsp;
    int            npop;
    int            first_pop;
    int            last_pop;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        bit exp_rv, pop, elig, conf, gw, gr;
        #1;
        exp_rv = (exp_q.size() > 0) && (due_q[0] <= cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) chk("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
        pop  = exp_rv && rsp_ready;
        elig = exp_q.size() < (2 + int'(pop));
        conf = wr_valid && rd_valid && elig;
        gw   = wr_valid && (!conf || !rr_rd);
        gr   = rd_valid && elig && (!conf || rr_rd);
        chk("wr_ready", 32'(wr_ready), 32'(gw));
        chk("rd_ready", 32'(rd_ready), 32'(gr));
        chk("ram_wren", 32'(ram_wren), 32'(gw));
        chk("ram_address", 32'(ram_address), 32'(gw ? wr_addr : rd_addr));
        if (gw) chk("ram_data", 32'(ram_data), 32'(wr_data));
        if (conf) rr_rd = !rr_rd;
        if (pop) begin
            last_rsp = rsp_data;
            npop++;
            if (npop == 1) first_pop = cyc;
            last_pop = cyc;
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (gw) ref_mem[wr_addr] = wr_data;
        if (gr) begin
            exp_q.push_back(ref_mem[rd_addr]);
            due_q.push_back(cyc + 2);
        end
        last_gw = gw;
        last_gr = gr;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic drive(input bit wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input bit rv,
                         input logic [AW-1:0] ra, input bit rr);
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        rsp_ready = rr;
        tick();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_wr_ready", 32'(wr_ready), 32'd0);
            chk("rst_rd_ready", 32'(rd_ready), 32'd0);
            chk("rst_ram_wren", 32'(ram_wren), 32'd0);
            @(posedge clock);
            cyc++;
            @(negedge clock);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        exp_q.delete();
        due_q.delete();
        rr_rd   = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [5:0] pat;
        int         nacc;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rr_rd    = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_val(AW'(i));
        reset_n   = 1'b0;
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        rsp_ready = 1'b1;
        @(negedge clock);
        do_reset(3);

        // single write then read back
        drive(1, 12'h010, 8'hA5, 0, 12'h000, 1);
        drive(0, 12'h000, 8'h00, 1, 12'h010, 1);
        for (int i = 0; i < 3; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);
        chk("t_wr_rd_data", 32'(last_rsp), 32'hA5);

        // both channels requesting from reset alternate W,R,...
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        do_reset(1);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive(1, AW'(12'h100 + i), DW'(8'h60 + i), 1, AW'(12'h100 + i), 1);
            pat = {pat[4:0], last_gw};
        end
        chk("t_alt_wren", 32'(pat), 32'h2A);
        for (int i = 0; i < 4; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);

        // back-to-back reads, no stall
        npop = 0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 12'h000, 8'h00, 1, AW'(i), 1);
            nacc += int'(last_gr);
        end
        for (int i = 0; i < 3; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);
        chk("t_b2b_acc", 32'(nacc), 32'd8);
        chk("t_b2b_pops", 32'(npop), 32'd8);
        chk("t_b2b_span", 32'(last_pop - first_pop), 32'd7);

        // backpressure: only two reads outstanding
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 12'h000, 8'h00, 1, AW'(12'h020 + i), 0);
            nacc += int'(last_gr);
        end
        chk("t_bp_acc", 32'(nacc), 32'd2);
        chk("t_bp_stall", 32'(rd_ready), 32'd0);
        npop = 0;
        for (int i = 0; i < 4; i++) drive(0, 12'h000, 8'h00, 1, AW'(12'h030 + i), 1);
        for (int i = 0; i < 4; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);
        chk("t_bp_pops", 32'(npop), 32'd6);

        // write then immediate read of same address
        drive(1, 12'h3FF, 8'h5A, 0, 12'h000, 1);
        drive(0, 12'h000, 8'h00, 1, 12'h3FF, 1);
        for (int i = 0; i < 3; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);
        chk("t_raw_data", 32'(last_rsp), 32'h5A);

        // reset right after a read accept discards the response
        drive(0, 12'h000, 8'h00, 1, 12'h3FF, 1);
        rd_valid = 1'b0;
        do_reset(2);
        npop = 0;
        for (int i = 0; i < 5; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);
        chk("t_rst_no_rsp", 32'(npop), 32'd0);

        // random traffic on a small address window
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                wr_valid = 1'($urandom);
                rd_valid = 1'($urandom);
                do_reset($urandom_range(1, 2));
            end else begin
                drive(1'($urandom_range(0, 2) == 0),
                      AW'($urandom_range(0, 15)),
                      DW'($urandom),
                      1'($urandom_range(0, 3) != 0),
                      AW'($urandom_range(0, 15)),
                      1'($urandom_range(0, 2) != 0));
            end
        end
        for (int i = 0; i < 5; i++) drive(0, 12'h000, 8'h00, 0, 12'h000, 1);
        chk("t_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
